// File: rtl/inst_mem_sync.sv
// ---------------------------------------------------------------------------
// Module: inst_mem_sync
// Purpose:
//   Synchronous instruction memory for the RISC-V fetch stage. A fetch request
//   (byte address = PC) is accepted with a valid/ready handshake, and the
//   instruction appears on a registered response port exactly one cycle later.
//   The response port also uses valid/ready, so fetch can stall. A flush drops
//   the pending response and refuses the request offered in the same cycle.
//   Misaligned and out-of-range fetches are answered with NOP_INST and
//   rsp_fault=1.
//
// Configuration macro:
//   INST_MEM_LOAD_EN  when defined, adds the ld_* runtime load port used for
//                     program download. When undefined, the memory is
//                     read-only after initialisation.
//
// Ports:
//   clk        in   1        clock, all state updates on the rising edge
//   rst        in   1        synchronous active-high reset
//   req_valid  in   1        fetch request present
//   req_ready  out  1        request accepted when req_valid && req_ready
//   req_addr   in   ADDR_W   byte address of the fetch
//   flush      in   1        drop the pending response and this cycle's request
//   rsp_valid  out  1        rsp_inst / rsp_fault are valid
//   rsp_ready  in   1        consumer accepts the response
//   rsp_inst   out  DATA_W   fetched instruction (NOP_INST on a fault)
//   rsp_fault  out  1        1 = misaligned or out-of-range fetch
//   fetch_cnt  out  16       accepted non-faulting requests, wraps
//   ld_en      in   1        (INST_MEM_LOAD_EN) load write strobe
//   ld_addr    in   IDX_W    (INST_MEM_LOAD_EN) word index to write
//   ld_data    in   DATA_W   (INST_MEM_LOAD_EN) word to write
// ---------------------------------------------------------------------------
module inst_mem_sync #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       ADDR_W    = 32,
  parameter string             INIT_FILE = "",
  parameter logic [DATA_W-1:0] NOP_INST  = 32'h13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic              rsp_fault,
  output logic [15:0]       fetch_cnt
`ifdef INST_MEM_LOAD_EN
  ,
  input  logic                       ld_en,
  input  logic [$clog2(DEPTH)-1:0]   ld_addr,
  input  logic [DATA_W-1:0]          ld_data
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rsp_inst_q, rsp_inst_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [15:0]       fetch_cnt_q, fetch_cnt_d;

  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic              accept;
  logic [DATA_W-1:0] rd_word;

  // The memory starts all zero. Reset never touches the contents.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = '0;
    end
  end

  // Address decode: word index from the byte address, plus the two fault
  // reasons. The index range check matters only when DEPTH is not a power
  // of two; otherwise the upper-bit check covers everything.
  assign idx          = req_addr[IDX_W+1:2];
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = (req_addr[ADDR_W-1:IDX_W+2] != '0) ||
                        (32'(idx) >= 32'(DEPTH));
  assign fault        = misaligned || out_of_range;
  assign rd_word      = mem[idx];

  // The response register is a one-deep buffer, so a new request fits
  // whenever the buffer is empty or is being drained this cycle. This never
  // looks at req_valid, which avoids a combinational valid->ready path.
  assign req_ready = (state_q == EMPTY) || rsp_ready;
  assign accept    = req_valid && req_ready && !flush;

  assign rsp_valid = (state_q == FULL);
  assign rsp_inst  = rsp_inst_q;
  assign rsp_fault = rsp_fault_q;
  assign fetch_cnt = fetch_cnt_q;

  // Next-state logic. Flush wins over an accept. A faulting accept loads the
  // NOP and does not count as a fetch. Data is held while the buffer is full
  // and not drained, so stalls leave the response stable.
  always_comb begin
    state_d     = state_q;
    rsp_inst_d  = rsp_inst_q;
    rsp_fault_d = rsp_fault_q;
    fetch_cnt_d = fetch_cnt_q;

    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d     = FULL;
      rsp_fault_d = fault;
      if (fault) begin
        rsp_inst_d = NOP_INST;
      end else begin
        rsp_inst_d  = rd_word;
        fetch_cnt_d = fetch_cnt_q + 16'd1;
      end
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // State and response registers. Reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      rsp_inst_q  <= '0;
      rsp_fault_q <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_fault_q <= rsp_fault_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

`ifdef INST_MEM_LOAD_EN
  // Program download port. The fetch path reads the memory combinationally
  // before this edge, so a same-cycle fetch of the loaded word returns the
  // old contents. Loads ignore reset and out-of-range indices.
  always_ff @(posedge clk) begin
    if (ld_en && (32'(ld_addr) < 32'(DEPTH))) begin
      mem[ld_addr] <= ld_data;
    end
  end
`endif

endmodule
